// File: rtl/round_sequencer.sv
// Game-round controller: title -> play -> level/win/fail pages, with level, score and timer state.
// Define ROUND_PAUSE_EN to add a pause_i port that freezes the timer and blocks new grabs.
module round_sequencer #(
    parameter int unsigned NUM_LEVELS = 3,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned VAL_W      = 5,
    parameter int unsigned TIME_W     = 6,
    parameter int unsigned ROUND_TIME = 30,
    parameter int unsigned HOLD_TICKS = 5,
    parameter logic [NUM_LEVELS*SCORE_W-1:0] TARGETS = {8'd5, 8'd3, 8'd2}
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              start_i,
    input  logic                              grab_i,
    input  logic                              tick_i,
`ifdef ROUND_PAUSE_EN
    input  logic                              pause_i,
`endif
    input  logic                              grab_done_i,
    input  logic [VAL_W-1:0]                  grab_value_i,
    input  logic                              page_done_i,
    input  logic                              audio_done_i,
    output logic                              page_req_o,
    output logic [1:0]                        page_sel_o,
    output logic                              grab_req_o,
    output logic                              audio_req_o,
    output logic                              audio_sel_o,
    output logic [$clog2(NUM_LEVELS+1)-1:0]   level_o,
    output logic [SCORE_W-1:0]                score_o,
    output logic [TIME_W-1:0]                 time_left_o
);

    localparam int unsigned LvlW  = $clog2(NUM_LEVELS + 1);
    localparam int unsigned HoldW = $clog2(HOLD_TICKS + 2);
    localparam int unsigned SumW  = ((SCORE_W > VAL_W) ? SCORE_W : VAL_W) + 1;

    localparam logic [SumW-1:0] ScoreMax  = SumW'((1 << SCORE_W) - 1);
    localparam logic [1:0]      PageTitle = 2'd0;
    localparam logic [1:0]      PageLevel = 2'd1;
    localparam logic [1:0]      PageWin   = 2'd2;
    localparam logic [1:0]      PageFail  = 2'd3;

    typedef enum logic [3:0] {
        StIdle,
        StTitle,
        StReady,
        StPlay,
        StGrab,
        StCheck,
        StLevelPage,
        StLevelHold,
        StWinPage,
        StFailPage,
        StAudio
    } state_e;

    state_e             state_q;
    logic               page_req_q;
    logic [1:0]         page_sel_q;
    logic               grab_req_q;
    logic               audio_req_q;
    logic               audio_sel_q;
    logic [LvlW-1:0]    level_q;
    logic [SCORE_W-1:0] score_q;
    logic [TIME_W-1:0]  time_q;
    logic [HoldW-1:0]   hold_q;

    logic               paused;
    logic               tick_run;
    logic               time_zero;
    logic [TIME_W-1:0]  time_dec;
    logic [SumW-1:0]    sum;
    logic [SCORE_W-1:0] score_sat;
    logic [LvlW-1:0]    lvl_idx;
    logic [SCORE_W-1:0] target;
    logic               target_met;
    logic               last_level;

`ifdef ROUND_PAUSE_EN
    assign paused = pause_i;
`else
    assign paused = 1'b0;
`endif

    assign tick_run   = tick_i & ~paused;
    assign time_zero  = (time_q == '0);
    assign time_dec   = time_zero ? time_q : time_q - TIME_W'(1);

    // Widen before adding so the carry out of the score width is visible for saturation.
    assign sum        = SumW'(score_q) + SumW'(grab_value_i);
    assign score_sat  = (sum > ScoreMax) ? {SCORE_W{1'b1}} : SCORE_W'(sum);

    assign lvl_idx    = level_q - LvlW'(1);
    assign target     = TARGETS[32'(lvl_idx) * SCORE_W +: SCORE_W];
    assign target_met = (score_q >= target);
    assign last_level = (level_q == LvlW'(NUM_LEVELS));

    // Each request state raises its req one cycle after entry, so sel is already settled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            page_req_q  <= 1'b0;
            page_sel_q  <= PageTitle;
            grab_req_q  <= 1'b0;
            audio_req_q <= 1'b0;
            audio_sel_q <= 1'b0;
            level_q     <= LvlW'(1);
            score_q     <= '0;
            time_q      <= '0;
            hold_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StTitle;
                end

                StTitle: begin
                    level_q <= LvlW'(1);
                    score_q <= '0;
                    if (!page_req_q) begin
                        page_req_q <= 1'b1;
                        page_sel_q <= PageTitle;
                    end else if (page_done_i) begin
                        page_req_q <= 1'b0;
                        state_q    <= StReady;
                    end
                end

                StReady: begin
                    if (start_i) begin
                        time_q  <= TIME_W'(ROUND_TIME);
                        score_q <= '0;
                        state_q <= StPlay;
                    end
                end

                StPlay: begin
                    if (time_zero) begin
                        state_q <= StFailPage;
                    end else begin
                        if (tick_run) begin
                            time_q <= time_dec;
                        end
                        if (grab_i && !paused) begin
                            state_q <= StGrab;
                        end
                    end
                end

                StGrab: begin
                    if (tick_run) begin
                        time_q <= time_dec;
                    end
                    if (!grab_req_q) begin
                        grab_req_q <= 1'b1;
                    end else if (grab_done_i) begin
                        grab_req_q <= 1'b0;
                        score_q    <= score_sat;
                        state_q    <= StCheck;
                    end
                end

                StCheck: begin
                    if (target_met) begin
                        state_q <= last_level ? StWinPage : StLevelPage;
                    end else if (time_zero) begin
                        state_q <= StFailPage;
                    end else begin
                        state_q <= StPlay;
                    end
                end

                StLevelPage: begin
                    if (!page_req_q) begin
                        page_req_q <= 1'b1;
                        page_sel_q <= PageLevel;
                    end else if (page_done_i) begin
                        page_req_q <= 1'b0;
                        level_q    <= level_q + LvlW'(1);
                        score_q    <= '0;
                        hold_q     <= '0;
                        state_q    <= StLevelHold;
                    end
                end

                StLevelHold: begin
                    if (hold_q == HoldW'(HOLD_TICKS)) begin
                        time_q  <= TIME_W'(ROUND_TIME);
                        state_q <= StPlay;
                    end else if (tick_i) begin
                        hold_q <= hold_q + HoldW'(1);
                    end
                end

                StWinPage, StFailPage: begin
                    if (!page_req_q) begin
                        page_req_q <= 1'b1;
                        page_sel_q <= (state_q == StWinPage) ? PageWin : PageFail;
                    end else if (page_done_i) begin
                        page_req_q  <= 1'b0;
                        audio_sel_q <= (state_q == StFailPage);
                        state_q     <= StAudio;
                    end
                end

                StAudio: begin
                    if (!audio_req_q) begin
                        audio_req_q <= 1'b1;
                    end else if (audio_done_i) begin
                        audio_req_q <= 1'b0;
                        state_q     <= StTitle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign page_req_o  = page_req_q;
    assign page_sel_o  = page_sel_q;
    assign grab_req_o  = grab_req_q;
    assign audio_req_o = audio_req_q;
    assign audio_sel_o = audio_sel_q;
    assign level_o     = level_q;
    assign score_o     = score_q;
    assign time_left_o = time_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed corner cases plus randomized games against a game-rule model.
module tb_round_sequencer;

    localparam int unsigned NumLevels = 3;
    localparam int unsigned ScoreW    = 4;
    localparam int unsigned ValW      = 5;
    localparam int unsigned TimeW     = 6;
    localparam int unsigned RoundTime = 30;
    localparam int unsigned HoldTicks = 5;
    localparam int          ScoreMax  = 15;

    logic              clk;
    logic              reset;
    logic              start;
    logic              grab;
    logic              tick;
    logic              grab_done;
    logic [ValW-1:0]   grab_value;
    logic              page_done;
    logic              audio_done;
    logic              page_req;
    logic [1:0]        page_sel;
    logic              grab_req;
    logic              audio_req;
    logic              audio_sel;
    logic [1:0]        level;
    logic [ScoreW-1:0] score;
    logic [TimeW-1:0]  time_left;
`ifdef ROUND_PAUSE_EN
    logic              pause;
`endif

    int n_vec;
    int n_err;

    // Game-rule model: level number, score within level, ticks remaining.
    int m_level;
    int m_score;
    int m_time;
    int tgt [3] = '{2, 3, 5};

    round_sequencer #(
        .NUM_LEVELS (NumLevels),
        .SCORE_W    (ScoreW),
        .VAL_W      (ValW),
        .TIME_W     (TimeW),
        .ROUND_TIME (RoundTime),
        .HOLD_TICKS (HoldTicks),
        .TARGETS    ({4'd5, 4'd3, 4'd2})
    ) u_dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .grab_i       (grab),
        .tick_i       (tick),
`ifdef ROUND_PAUSE_EN
        .pause_i      (pause),
`endif
        .grab_done_i  (grab_done),
        .grab_value_i (grab_value),
        .page_done_i  (page_done),
        .audio_done_i (audio_done),
        .page_req_o   (page_req),
        .page_sel_o   (page_sel),
        .grab_req_o   (grab_req),
        .audio_req_o  (audio_req),
        .audio_sel_o  (audio_sel),
        .level_o      (level),
        .score_o      (score),
        .time_left_o  (time_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic int outcome();
        if (m_score >= tgt[m_level-1]) return 0;
        if (m_time == 0) return 1;
        return -1;
    endfunction

    task automatic wait_page(input logic [1:0] sel);
        int i = 0;
        while (!page_req && i < 100) begin
            cyc();
            i++;
        end
        check("page_req_seen", 32'(page_req), 1);
        if (page_req) begin
            check("page_sel", 32'(page_sel), 32'(sel));
            page_done = 1'b1;
            cyc();
            page_done = 1'b0;
            check("page_req_drop", 32'(page_req), 0);
        end
    endtask

    task automatic wait_audio(input logic sel);
        int i = 0;
        while (!audio_req && i < 100) begin
            cyc();
            i++;
        end
        check("audio_req_seen", 32'(audio_req), 1);
        if (audio_req) begin
            check("audio_sel", 32'(audio_sel), 32'(sel));
            audio_done = 1'b1;
            cyc();
            audio_done = 1'b0;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic do_tick();
        pulse_tick();
        if (m_time > 0) m_time--;
    endtask

    // mode 0: no tick, 1: tick while the grab is outstanding, 2: tick together with grab_done.
    task automatic do_grab(input int v, input int mode);
        int i = 0;
        grab = 1'b1;
        cyc();
        grab = 1'b0;
        while (!grab_req && i < 100) begin
            cyc();
            i++;
        end
        check("grab_req_seen", 32'(grab_req), 1);
        if (mode == 1) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (m_time > 0) m_time--;
        end
        grab_done  = 1'b1;
        grab_value = ValW'(v);
        if (mode == 2) begin
            tick = 1'b1;
            if (m_time > 0) m_time--;
        end
        cyc();
        grab_done  = 1'b0;
        grab_value = '0;
        tick       = 1'b0;
        m_score = (m_score + v > ScoreMax) ? ScoreMax : m_score + v;
        check("score", 32'(score), 32'(m_score));
        check("time_left", 32'(time_left), 32'(m_time));
        cyc();
    endtask

    task automatic apply_reset();
        cyc();
        reset = 1'b1;
        #1;
        check("rst_page_req", 32'(page_req), 0);
        check("rst_grab_req", 32'(grab_req), 0);
        check("rst_audio_req", 32'(audio_req), 0);
        check("rst_page_sel", 32'(page_sel), 0);
        check("rst_audio_sel", 32'(audio_sel), 0);
        check("rst_level", 32'(level), 1);
        check("rst_score", 32'(score), 0);
        check("rst_time", 32'(time_left), 0);
        cyc();
        reset = 1'b0;
        cyc();
        check("rel_page_req_1", 32'(page_req), 0);
        cyc();
        check("rel_page_req_2", 32'(page_req), 1);
    endtask

    task automatic begin_game();
        wait_page(2'd0);
        check("title_level", 32'(level), 1);
        check("title_score", 32'(score), 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_level = 1;
        m_score = 0;
        m_time  = RoundTime;
        check("start_time", 32'(time_left), 32'(m_time));
    endtask

    task automatic play_level(output int res);
        int guard = 0;
        res = outcome();
        while (res < 0 && guard < 200) begin
            guard++;
            if ($urandom_range(0, 2) == 0) begin
                do_grab(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            end else begin
                do_tick();
            end
            res = outcome();
        end
    endtask

    task automatic finish_game();
        int res;
        bit over = 1'b0;
        while (!over) begin
            play_level(res);
            if (res == 1) begin
                wait_page(2'd3);
                wait_audio(1'b1);
                over = 1'b1;
            end else if (res == 0 && m_level == NumLevels) begin
                wait_page(2'd2);
                wait_audio(1'b0);
                over = 1'b1;
            end else if (res == 0) begin
                wait_page(2'd1);
                repeat (HoldTicks) pulse_tick();
                m_level++;
                m_score = 0;
                m_time  = RoundTime;
                check("next_level", 32'(level), 32'(m_level));
                check("next_score", 32'(score), 0);
                check("next_time", 32'(time_left), 32'(m_time));
            end else begin
                check("level_outcome", 32'(res), 0);
                over = 1'b1;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b0;
        start      = 1'b0;
        grab       = 1'b0;
        tick       = 1'b0;
        grab_done  = 1'b0;
        grab_value = '0;
        page_done  = 1'b0;
        audio_done = 1'b0;
`ifdef ROUND_PAUSE_EN
        pause      = 1'b0;
`endif
        apply_reset();

        // Level 1 cleared by 1 + 1, then the rest of the game at random.
        begin_game();
        do_grab(1, 0);
        do_grab(1, 0);
        finish_game();

        // Timer runs out; a grab in the cycle time hits zero must lose to the fail path.
        begin_game();
        repeat (RoundTime - 1) do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        grab = 1'b1;
        cyc();
        grab = 1'b0;
        m_time = 0;
        check("timeout_time", 32'(time_left), 0);
        check("timeout_no_grab", 32'(grab_req), 0);
        finish_game();

        // Final tick lands during the grab, grab misses.
        begin_game();
        repeat (RoundTime - 1) do_tick();
        do_grab(0, 1);
        finish_game();

        // Final tick together with grab_done, grab reaches the target.
        begin_game();
        repeat (RoundTime - 1) do_tick();
        do_grab(2, 2);
        check("late_clear", 32'(outcome()), 0);
        finish_game();

        // Saturation of the 4-bit score.
        begin_game();
        do_grab(1, 0);
        do_grab(31, 0);
        finish_game();

        // Reset while a grab is outstanding.
        begin_game();
        grab = 1'b1;
        cyc();
        grab = 1'b0;
        cyc();
        check("pre_reset_grab_req", 32'(grab_req), 1);
        apply_reset();

`ifdef ROUND_PAUSE_EN
        begin_game();
        pause = 1'b1;
        repeat (10) pulse_tick();
        check("pause_time", 32'(time_left), 32'(m_time));
        grab = 1'b1;
        cyc();
        grab = 1'b0;
        cyc();
        cyc();
        check("pause_no_grab", 32'(grab_req), 0);
        pause = 1'b0;
        finish_game();
`endif

        repeat (6) begin
            begin_game();
            finish_game();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
